// File: rtl/mlp_seq_pkg.sv
// Shared sizing constants and state encodings for the MLP frame sequencer.
package mlp_seq_pkg;

  localparam int unsigned W     = 18;
  localparam int unsigned N_IN  = 784;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned CLS_W = $clog2(N_OUT);

  typedef enum logic {
    StFill,
    StSend
  } in_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StScan,
    StResult
  } out_state_t;

endpackage

// File: rtl/mlp_argmax_scan.sv
// Sequential signed argmax: one class per cycle, lowest index wins on a tie.
module mlp_argmax_scan #(
  parameter int unsigned W     = 18,
  parameter int unsigned N_OUT = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [W*N_OUT-1:0]           scores,
  output logic [$clog2(N_OUT)-1:0]     idx,
  output logic [W-1:0]                 score,
  output logic                         done
);

  localparam int unsigned CW = $clog2(N_OUT);

  logic                 run_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        best_idx_q;
  logic signed [W-1:0]  best_q;
  logic signed [W-1:0]  cur;

  always_comb begin
    cur = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (cnt_q == CW'(j)) cur = $signed(scores[W*j +: W]);
    end
  end

  assign done  = run_q && (cnt_q == CW'(N_OUT - 1));
  assign idx   = best_idx_q;
  assign score = best_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (run_q) begin
      // Index 0 seeds the running best; afterwards only a strictly greater score replaces it.
      if (cnt_q == '0 || cur > best_q) begin
        best_q     <= cur;
        best_idx_q <= cnt_q;
      end
      if (done) run_q <= 1'b0;
      else      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Packs a pixel stream into frames for the mnist_mlp core, collects scores and
// returns the winning class with length and timeout error pulses.
module mlp_frame_sequencer #(
  parameter int unsigned W       = mlp_seq_pkg::W,
  parameter int unsigned N_IN    = mlp_seq_pkg::N_IN,
  parameter int unsigned N_OUT   = mlp_seq_pkg::N_OUT,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             pix_dat,
  input  logic                     pix_vld,
  input  logic                     pix_last,
  output logic                     pix_rdy,
  output logic [W*N_IN-1:0]        core_in_dat,
  output logic                     core_in_vld,
  input  logic                     core_in_rdy,
  input  logic [W*N_OUT-1:0]       core_out_dat,
  input  logic                     core_out_vld,
  output logic                     core_out_rdy,
  output logic [$clog2(N_OUT)-1:0] res_class,
  output logic [W-1:0]             res_score,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic                     busy
);

  import mlp_seq_pkg::*;

  localparam int unsigned PW = $clog2(N_IN);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(N_OUT);

  in_state_t           in_state;
  out_state_t          out_state;
  logic [PW-1:0]       pix_cnt;
  logic                pix_rdy_q;
  logic                err_len_q;
  logic [W*N_IN-1:0]   frame_q;
  logic [TW-1:0]       to_cnt;
  logic                err_to_q;
  logic [W*N_OUT-1:0]  scores_q;

  logic                pix_hs;
  logic                in_hs;
  logic                out_hs;
  logic                scan_done;
  logic [CW-1:0]       scan_idx;
  logic [W-1:0]        scan_score;

  // The core holds one frame at a time, so SEND only offers while the output side is idle.
  assign core_in_vld  = (in_state == StSend) && (out_state == StIdle);
  assign core_out_rdy = (out_state == StWait);
  assign res_vld      = (out_state == StResult);
  assign busy         = (out_state != StIdle);
  assign pix_rdy      = pix_rdy_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_to_q;
  assign core_in_dat  = frame_q;
  assign res_class    = scan_idx;
  assign res_score    = scan_score;

  assign pix_hs = pix_vld && pix_rdy_q && (in_state == StFill);
  assign in_hs  = core_in_vld && core_in_rdy;
  assign out_hs = core_out_vld && core_out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state  <= StFill;
      pix_cnt   <= '0;
      pix_rdy_q <= 1'b0;
      err_len_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      err_len_q <= 1'b0;
      unique case (in_state)
        StFill: begin
          pix_rdy_q <= 1'b1;
          if (pix_hs) begin
            for (int k = 0; k < N_IN; k++) begin
              if (pix_cnt == PW'(k)) frame_q[W*k +: W] <= pix_dat;
            end
            if (pix_cnt == PW'(N_IN - 1)) begin
              in_state  <= StSend;
              pix_rdy_q <= 1'b0;
              pix_cnt   <= '0;
              err_len_q <= ~pix_last;
            end else if (pix_last) begin
              // Short frame: drop it and start over; stale slots get overwritten.
              pix_cnt   <= '0;
              err_len_q <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + PW'(1);
            end
          end
        end
        StSend: begin
          if (in_hs) begin
            in_state  <= StFill;
            pix_rdy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= StIdle;
      to_cnt    <= '0;
      err_to_q  <= 1'b0;
      scores_q  <= '0;
    end else begin
      err_to_q <= 1'b0;
      unique case (out_state)
        StIdle: begin
          if (in_hs) begin
            out_state <= StWait;
            to_cnt    <= '0;
          end
        end
        StWait: begin
          // A late-arriving result on the final cycle still wins over the timeout.
          if (core_out_vld) begin
            scores_q  <= core_out_dat;
            out_state <= StScan;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            err_to_q  <= 1'b1;
            out_state <= StIdle;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        StScan: begin
          if (scan_done) out_state <= StResult;
        end
        StResult: begin
          if (res_rdy) out_state <= StIdle;
        end
      endcase
    end
  end

  mlp_argmax_scan #(
    .W     (W),
    .N_OUT (N_OUT)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (out_hs),
    .scores (scores_q),
    .idx    (scan_idx),
    .score  (scan_score),
    .done   (scan_done)
  );

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Directed bench for mlp_frame_sequencer with a hand-driven core stub.
module tb_mlp_frame_sequencer;

  localparam int unsigned W     = 18;
  localparam int unsigned N_IN  = 784;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned TO    = 100;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [W-1:0]         pix_dat = '0;
  logic                 pix_vld = 1'b0;
  logic                 pix_last = 1'b0;
  logic                 pix_rdy;
  logic [W*N_IN-1:0]    core_in_dat;
  logic                 core_in_vld;
  logic                 core_in_rdy = 1'b0;
  logic [W*N_OUT-1:0]   core_out_dat = '0;
  logic                 core_out_vld = 1'b0;
  logic                 core_out_rdy;
  logic [3:0]           res_class;
  logic [W-1:0]         res_score;
  logic                 res_vld;
  logic                 res_rdy = 1'b0;
  logic                 err_len;
  logic                 err_timeout;
  logic                 busy;

  logic [W-1:0]         sc [N_OUT];
  int                   n_tests = 0;
  int                   n_fail = 0;

  always #5 clk = ~clk;

  mlp_frame_sequencer #(
    .W       (W),
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_dat      (pix_dat),
    .pix_vld      (pix_vld),
    .pix_last     (pix_last),
    .pix_rdy      (pix_rdy),
    .core_in_dat  (core_in_dat),
    .core_in_vld  (core_in_vld),
    .core_in_rdy  (core_in_rdy),
    .core_out_dat (core_out_dat),
    .core_out_vld (core_out_vld),
    .core_out_rdy (core_out_rdy),
    .res_class    (res_class),
    .res_score    (res_score),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n pixels valued base+i; pix_last rides on index last_at (-1 for none).
  task automatic send_pixels(input int n, input int last_at, input int base);
    for (int i = 0; i < n; i++) begin
      pix_vld  = 1'b1;
      pix_dat  = 18'(base + i);
      pix_last = (i == last_at);
      for (int w = 0; !pix_rdy && w < 2000; w++) tick();
      if (!pix_rdy) begin
        check_eq("pix_rdy_stall", 0, 1);
        pix_vld  = 1'b0;
        pix_last = 1'b0;
        return;
      end
      tick();
    end
    pix_vld  = 1'b0;
    pix_last = 1'b0;
  endtask

  // Hands the pending frame to the core, returns scores from sc[] and checks the result.
  task automatic run_core(input string tag, input logic [3:0] exp_cls, input logic [W-1:0] exp_sc);
    int n;
    check_eq({tag, "_in_vld"}, core_in_vld, 1);
    core_in_rdy = 1'b1;
    tick();
    core_in_rdy = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    tick();
    tick();
    check_eq({tag, "_out_rdy"}, core_out_rdy, 1);
    for (int j = 0; j < N_OUT; j++) core_out_dat[W*j +: W] = sc[j];
    core_out_vld = 1'b1;
    tick();
    core_out_vld = 1'b0;
    n = 1;
    while (!res_vld && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, n, 11);
    check_eq({tag, "_class"}, res_class, exp_cls);
    check_eq({tag, "_score"}, res_score, exp_sc);
  endtask

  task automatic consume(input string tag);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check_eq({tag, "_res_vld_low"}, res_vld, 0);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    int held_bad;

    tick();
    tick();
    check_eq("rst_pix_rdy", pix_rdy, 0);
    check_eq("rst_in_vld", core_in_vld, 0);
    check_eq("rst_out_rdy", core_out_rdy, 0);
    check_eq("rst_res_vld", res_vld, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_len", err_len, 0);
    check_eq("rst_err_to", err_timeout, 0);
    check_eq("rst_in_dat", |core_in_dat, 0);
    check_eq("rst_res_class", res_class, 0);
    check_eq("rst_res_score", res_score, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_pix_rdy", pix_rdy, 1);

    // Nominal frame
    send_pixels(784, 783, 'h100);
    check_eq("nom_err_len", err_len, 0);
    check_eq("nom_pix_rdy", pix_rdy, 0);
    check_eq("nom_pix0", core_in_dat[0 +: W], 18'h00100);
    check_eq("nom_pix400", core_in_dat[W*400 +: W], 18'h00290);
    check_eq("nom_pix783", core_in_dat[W*783 +: W], 18'h0040F);
    sc = '{18'h00000, 18'h00005, 18'h3FFFF, 18'h00FF0, 18'h00000,
           18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
    run_core("nom", 4'd3, 18'h00FF0);

    // Next frame fills while the result is held back
    send_pixels(784, 783, 'h2000);
    held_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (core_in_vld !== 1'b0 || res_vld !== 1'b1 || res_class !== 4'd3 ||
          res_score !== 18'h00FF0) held_bad++;
      tick();
    end
    check_eq("hold_stable", held_bad, 0);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check_eq("hold_res_vld_low", res_vld, 0);
    check_eq("hold_in_vld_after", core_in_vld, 1);
    check_eq("hold_pix783", core_in_dat[W*783 +: W], 18'h0230F);

    // Tie between classes 2 and 7
    sc = '{18'h3FF00, 18'h3FFF0, 18'h00100, 18'h20000, 18'h3FFFF,
           18'h3F000, 18'h30000, 18'h00100, 18'h3FFFE, 18'h2ABCD};
    run_core("tie", 4'd2, 18'h00100);
    consume("tie");

    // Early pix_last on pixel 99
    send_pixels(100, 99, 'h3000);
    check_eq("early_err_len", err_len, 1);
    check_eq("early_in_vld", core_in_vld, 0);
    tick();
    check_eq("early_err_pulse", err_len, 0);
    check_eq("early_pix_rdy", pix_rdy, 1);
    send_pixels(784, 783, 'h5000);
    check_eq("clean_err_len", err_len, 0);
    check_eq("clean_pix0", core_in_dat[0 +: W], 18'h05000);
    sc = '{18'h20000, 18'h20000, 18'h20000, 18'h20000, 18'h20000,
           18'h20000, 18'h20000, 18'h20000, 18'h00000, 18'h00001};
    run_core("lastidx", 4'd9, 18'h00001);
    consume("lastidx");

    // Missing pix_last on pixel 783
    send_pixels(784, -1, 'h6000);
    check_eq("miss_err_len", err_len, 1);
    check_eq("miss_in_vld", core_in_vld, 1);

    // Core never answers
    core_in_rdy = 1'b1;
    tick();
    core_in_rdy = 1'b0;
    n = 1;
    while (!err_timeout && n < 300) begin
      tick();
      n++;
    end
    check_eq("to_latency", n, 101);
    check_eq("to_busy", busy, 0);
    check_eq("to_res_vld", res_vld, 0);
    tick();
    check_eq("to_pulse", err_timeout, 0);

    // Reset in the middle of a frame
    send_pixels(400, -1, 'h7000);
    rst = 1'b1;
    tick();
    check_eq("mrst_pix_rdy", pix_rdy, 0);
    check_eq("mrst_in_dat", |core_in_dat, 0);
    check_eq("mrst_in_vld", core_in_vld, 0);
    check_eq("mrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    check_eq("mrst_pix_rdy_low", pix_rdy, 0);
    tick();
    check_eq("mrst_pix_rdy_high", pix_rdy, 1);
    send_pixels(784, 783, 'h8000);
    check_eq("mrst_err_len", err_len, 0);
    check_eq("mrst_in_vld_full", core_in_vld, 1);
    check_eq("mrst_pix0", core_in_dat[0 +: W], 18'h08000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
